// File: rtl/spi_flash_wb_reader.sv
// spi_flash_wb_reader
//   Read-only Wishbone B3 slave that serves 32-bit reads from an SPI serial
//   flash. It uses mode 0 and the READ command 0x03. After a read completes,
//   SS stays low for a short time. A read of the next word during that time
//   skips the command and address phase.
//
// Ports
//   wb_clk_i, wb_rst_i   : the only clock; synchronous active-high reset
//   wb_adr_i             : byte address; [ADR_WIDTH-1:2] used
//   wb_dat_i, wb_sel_i   : unused (read-only, always full word)
//   wb_we_i              : write enable; writes are answered with wb_err_o
//   wb_cyc_i, wb_stb_i   : bus cycle / strobe
//   wb_dat_o             : read data, first flash byte in [31:24]
//   wb_ack_o, wb_err_o   : one-cycle completion pulses, never together
//   sck_o, ss_o, mosi_o  : SPI clock (idles low), select (active low), data out
//   miso_i               : SPI data in
//   dbg_state_o          : current FSM state, for observation only
//
// Handshake: the master raises cyc & stb with the address. It holds all
// three until it sees exactly one wb_ack_o or wb_err_o pulse, then drops stb
// before the next clock edge. This is a classic cycle with no pipelining.
// A strobe seen in the cycle of a response pulse is not a new request.
module spi_flash_wb_reader #(
    parameter int SCK_DIV     = 2,
    parameter int ADR_WIDTH   = 24,
    parameter int HOLD_CYCLES = 16,
    parameter int SS_GAP      = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        sck_o,
    output logic        ss_o,
    output logic        mosi_o,
    input  logic        miso_i,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ACK, HOLD, DESEL} state_t;

    localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int GW = $clog2(SS_GAP + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(SCK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(SS_GAP - 1);
    localparam logic [7:0]    CMD_READ  = 8'h03;

    state_t               state;
    logic [DW-1:0]        div_cnt;
    logic [4:0]           bit_cnt;
    logic [4:0]           bit_last;
    logic [31:0]          shreg;      // [31] is the bit currently on mosi_o
    logic [ADR_WIDTH-1:0] adr_q;      // transfer address, then next sequential address
    logic                 hold_valid;
    logic [HW-1:0]        hold_cnt;
    logic [GW-1:0]        gap_cnt;    // cycles ss_o has been high, saturating

    logic                 rd_req;
    logic                 wr_req;
    logic                 gap_ok;
    logic [ADR_WIDTH-1:0] req_adr;
    logic [23:0]          adr_field;
    logic                 unused_ok;

    assign rd_req      = wb_cyc_i & wb_stb_i & ~wb_we_i;
    assign wr_req      = wb_cyc_i & wb_stb_i & wb_we_i;
    assign req_adr     = {wb_adr_i[ADR_WIDTH-1:2], 2'b00};
    assign adr_field   = 24'(adr_q);
    assign gap_ok      = (gap_cnt == GAP_LAST);
    assign dbg_state_o = state;
    assign unused_ok   = &{1'b0, wb_dat_i, wb_sel_i, wb_adr_i[1:0], wb_adr_i[31:ADR_WIDTH]};

    always_comb begin
        bit_last = 5'd31;
        if (state == CMD)       bit_last = 5'd7;
        else if (state == ADDR) bit_last = 5'd23;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            ss_o       <= 1'b1;
            sck_o      <= 1'b0;
            mosi_o     <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wb_dat_o   <= '0;
            adr_q      <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            hold_cnt   <= '0;
            hold_valid <= 1'b0;
            gap_cnt    <= '0;   // deselect gap restarts even after a reset
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            if (!ss_o)        gap_cnt <= '0;
            else if (!gap_ok) gap_cnt <= gap_cnt + 1'b1;

            case (state)
                // DESEL waits out the gap, then decides exactly like IDLE
                // so a request that forced the deselect is served at once.
                IDLE, DESEL: begin
                    if (gap_ok) begin
                        if (rd_req) begin
                            state   <= CMD;
                            ss_o    <= 1'b0;
                            sck_o   <= 1'b0;
                            adr_q   <= req_adr;
                            shreg   <= {CMD_READ, 24'h0};
                            mosi_o  <= CMD_READ[7];
                            bit_cnt <= '0;
                            div_cnt <= '0;
                        end else if (wr_req && !wb_err_o) begin
                            wb_err_o <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                CMD, ADDR, DATA: begin
                    if (!wb_cyc_i) begin
                        state      <= DESEL;
                        ss_o       <= 1'b1;
                        sck_o      <= 1'b0;
                        mosi_o     <= 1'b0;
                        hold_valid <= 1'b0;
                    end else begin
                        // sample in the first cycle sck is high
                        if (state == DATA && sck_o && div_cnt == '0)
                            wb_dat_o <= {wb_dat_o[30:0], miso_i};
                        if (div_cnt != DIV_LAST) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else begin
                            div_cnt <= '0;
                            if (!sck_o) begin
                                sck_o <= 1'b1;
                            end else begin
                                sck_o <= 1'b0;
                                if (bit_cnt != bit_last) begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    shreg   <= {shreg[30:0], 1'b0};
                                    mosi_o  <= shreg[30];
                                end else begin
                                    bit_cnt <= '0;
                                    case (state)
                                        CMD: begin
                                            state  <= ADDR;
                                            shreg  <= {adr_field, 8'h00};
                                            mosi_o <= adr_field[23];
                                        end
                                        ADDR: begin
                                            state  <= DATA;
                                            mosi_o <= 1'b0;
                                        end
                                        default: begin
                                            state    <= ACK;
                                            wb_ack_o <= 1'b1;
                                            mosi_o   <= 1'b0;
                                        end
                                    endcase
                                end
                            end
                        end
                    end
                end

                ACK: begin
                    state      <= HOLD;
                    adr_q      <= adr_q + ADR_WIDTH'(4);
                    hold_valid <= 1'b1;
                    hold_cnt   <= HW'(1);   // the ACK cycle is the first idle cycle
                end

                HOLD: begin
                    if (rd_req && hold_valid && req_adr == adr_q) begin
                        // flash is still streaming: go straight to data bits
                        state   <= DATA;
                        sck_o   <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else if (rd_req || wr_req || hold_cnt == HOLD_LAST) begin
                        state      <= DESEL;
                        ss_o       <= 1'b1;
                        hold_valid <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_wb_reader.sv
module tb_spi_flash_wb_reader;

    localparam int M = 1024;      // flash model size in bytes (addresses wrap)
    localparam int SD0 = 2;       // SCK_DIV of the main instance
    localparam int SD1 = 1;       // SCK_DIV of the fast instance
    localparam int GAP = 2;
    localparam int HOLD = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- bus and DUTs ----------------
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        fast = 1'b0;   // selects which instance the bus and flash talk to
    logic        miso = 1'b0;

    logic [31:0] dat0, dat1;
    logic        ack0, ack1, err0, err1, sck0, sck1, ss0, ss1, mosi0, mosi1;
    logic [2:0]  st0, st1;

    spi_flash_wb_reader #(.SCK_DIV(SD0), .ADR_WIDTH(24), .HOLD_CYCLES(HOLD), .SS_GAP(GAP)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc & ~fast), .wb_stb_i(stb & ~fast),
        .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0),
        .sck_o(sck0), .ss_o(ss0), .mosi_o(mosi0), .miso_i(miso), .dbg_state_o(st0)
    );

    spi_flash_wb_reader #(.SCK_DIV(SD1), .ADR_WIDTH(24), .HOLD_CYCLES(HOLD), .SS_GAP(GAP)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc & fast), .wb_stb_i(stb & fast),
        .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1),
        .sck_o(sck1), .ss_o(ss1), .mosi_o(mosi1), .miso_i(miso), .dbg_state_o(st1)
    );

    logic [31:0] m_dat;
    logic        m_ack, m_err, m_sck, m_ss, m_mosi;
    assign m_dat  = fast ? dat1  : dat0;
    assign m_ack  = fast ? ack1  : ack0;
    assign m_err  = fast ? err1  : err0;
    assign m_sck  = fast ? sck1  : sck0;
    assign m_ss   = fast ? ss1   : ss0;
    assign m_mosi = fast ? mosi1 : mosi0;

    // ---------------- SPI flash model ----------------
    logic [7:0]  mem [0:M-1];
    int          rx_cnt = 0;
    logic [7:0]  cmd_rx = '0;
    logic [23:0] adr_rx = '0;
    int          sck_rises = 0, ss_rises = 0, ss_falls = 0, ss_high_last = 0;
    time         t_ss_rise = 0;

    always @(posedge m_ss or posedge m_sck) begin
        if (m_ss === 1'b1) begin
            rx_cnt = 0;
        end else begin
            if (rx_cnt < 8)       cmd_rx = {cmd_rx[6:0], m_mosi};
            else if (rx_cnt < 32) adr_rx = {adr_rx[22:0], m_mosi};
            rx_cnt++;
            sck_rises++;
        end
    end

    always @(negedge m_sck) begin
        if (m_ss === 1'b0 && rx_cnt >= 32) begin
            int k;
            logic [7:0] b;
            k = rx_cnt - 32;
            b = mem[(int'(adr_rx) + k / 8) % M];
            miso = b[7 - (k % 8)];
        end
    end

    always @(posedge m_ss) begin
        ss_rises++;
        t_ss_rise = $time;
    end
    always @(negedge m_ss) begin
        ss_falls++;
        ss_high_last = int'(($time - t_ss_rise) / 10);
    end

    int ack_cnt = 0;
    always @(negedge clk) if (m_ack === 1'b1) ack_cnt++;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] ref_word(input int a);
        return {mem[a % M], mem[(a + 1) % M], mem[(a + 2) % M], mem[(a + 3) % M]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d, output logic ok);
        @(posedge clk); #1;
        adr = a; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        lat = 0; ok = 1'b0; d = '0;
        while (!ok && lat < 3000) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (m_ack === 1'b1) begin
                ok = 1'b1;
                d = m_dat;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, output int lat, output logic got_err, output logic got_ack);
        @(posedge clk); #1;
        adr = a; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        lat = 0; got_err = 1'b0; got_ack = 1'b0;
        while (!got_err && !got_ack && lat < 500) begin
            @(posedge clk); lat++;
            @(negedge clk);
            if (m_err === 1'b1) got_err = 1'b1;
            if (m_ack === 1'b1) got_ack = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input int exp_lat);
        int lat;
        logic [31:0] d;
        logic ok;
        exp_q.push_back(ref_word(int'(a)));
        do_read(a, lat, d, ok);
        chk({tag, "_ack"}, 32'(ok), 32'd1);
        if (exp_lat > 0) chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_data"}, d, exp_q.pop_front());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat, n, r0, f0, q0, a0, prev, a;
        logic [31:0] d;
        logic ok, ge, ga;

        for (int i = 0; i < M; i++) mem[i] = 8'($urandom);
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        cyc = 0; stb = 0; we = 0; adr = '0; wdat = 32'hdead_beef; sel = 4'hf;

        // reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ss", 32'(m_ss), 32'd1);
        chk("rst_sck", 32'(m_sck), 32'd0);
        chk("rst_mosi", 32'(m_mosi), 32'd0);
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_dat", m_dat, 32'h0);
        rst = 1'b0;
        idle(5);

        // 1: full read of 0x100
        read_chk("t1", 32'h100, 1 + 128 * SD0);
        chk("t1_cmd", 32'(cmd_rx), 32'h03);
        chk("t1_adr", 32'(adr_rx), 32'h000100);

        // 2: sequential read keeps SS low and only clocks data
        r0 = sck_rises; f0 = ss_falls; q0 = ss_rises;
        read_chk("t2", 32'h104, 1 + 64 * SD0);
        chk("t2_sck_pulses", 32'(sck_rises - r0), 32'd32);
        chk("t2_ss_rise", 32'(ss_rises - q0), 32'd0);
        chk("t2_ss_fall", 32'(ss_falls - f0), 32'd0);

        // 3: non-sequential read from hold: deselect, gap, full command
        read_chk("t3", 32'h200, 1 + GAP + 128 * SD0);
        chk("t3_cmd", 32'(cmd_rx), 32'h03);
        chk("t3_adr", 32'(adr_rx), 32'h000200);
        chk("t3_gap", 32'(ss_high_last >= GAP), 32'd1);

        // 4a: SS released HOLD cycles after the ack
        n = 0;
        while (n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (m_ss === 1'b1) break;
        end
        chk("t4_hold_release", 32'(n), 32'(HOLD));

        // 4b: write while idle
        idle(3);
        r0 = sck_rises; f0 = ss_falls; a0 = ack_cnt;
        do_write(32'($urandom_range(0, 255) * 4), lat, ge, ga);
        chk("t4_err", 32'(ge), 32'd1);
        chk("t4_err_lat", 32'(lat), 32'd1);
        chk("t4_no_ack", 32'(ga), 32'd0);
        @(negedge clk);
        chk("t4_err_pulse", 32'(m_err), 32'd0);
        chk("t4_no_sck", 32'(sck_rises - r0), 32'd0);
        chk("t4_ss_kept", 32'(ss_falls - f0), 32'd0);
        chk("t4_ss_high", 32'(m_ss), 32'd1);

        // 4c: write during hold is answered after the deselect gap
        read_chk("t4c_rd", 32'h040, 0);
        do_write(32'h040, lat, ge, ga);
        chk("t4c_err", 32'(ge), 32'd1);
        chk("t4c_err_lat", 32'(lat), 32'(1 + GAP));
        chk("t4c_ss", 32'(m_ss), 32'd1);

        // 5: abort in the address phase
        idle(3);
        @(posedge clk); #1;
        adr = 32'h300; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        n = rx_cnt; a0 = ack_cnt;
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_in_addr", 32'(n > 8 && n < 32), 32'd1);
        chk("t5_ss", 32'(m_ss), 32'd1);
        chk("t5_sck", 32'(m_sck), 32'd0);
        idle(10);
        chk("t5_no_ack", 32'(ack_cnt - a0), 32'd0);
        read_chk("t5_retry", 32'h300, 1 + 128 * SD0);
        chk("t5_cmd", 32'(cmd_rx), 32'h03);
        chk("t5_adr", 32'(adr_rx), 32'h000300);

        // 6: reset during the data phase
        idle(30);
        @(posedge clk); #1;
        adr = 32'h104; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_ss", 32'(m_ss), 32'd1);
        chk("t6_sck", 32'(m_sck), 32'd0);
        chk("t6_mosi", 32'(m_mosi), 32'd0);
        chk("t6_ack", 32'(m_ack), 32'd0);
        chk("t6_err", 32'(m_err), 32'd0);
        chk("t6_dat", m_dat, 32'h0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        idle(5);
        read_chk("t6_after", 32'h104, 1 + 128 * SD0);

        // SCK_DIV=1 instance
        idle(30);
        fast = 1'b1;
        idle(4);
        read_chk("f1", 32'h100, 1 + 128 * SD1);
        read_chk("f2", 32'h104, 1 + 64 * SD1);

        // random reads, sequential or not, back to back
        prev = 32'h104;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) a = prev + 4;
            else a = $urandom_range(0, 255) * 4;
            read_chk($sformatf("rnd%0d", i), 32'(a),
                     (a == prev + 4) ? (1 + 64 * SD1) : (1 + GAP + 128 * SD1));
            prev = a;
        end

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
